// File: rtl/rv32_pipeline_pkg.sv
// Shared RV32IMF pipeline definitions: fetch state encoding, canonical NOP,
// reset vector default and the base opcodes the decoder switches on.
package rv32_pipeline_pkg;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'b00,
    FS_FETCH   = 2'b01,
    FS_HOLD    = 2'b10,
    FS_DISCARD = 2'b11
  } fetch_state_t;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPCODE_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPCODE_LOAD_FP  = 7'b000_0111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPCODE_STORE    = 7'b010_0011;
  localparam logic [6:0] OPCODE_STORE_FP = 7'b010_0111;
  localparam logic [6:0] OPCODE_OP       = 7'b011_0011;
  localparam logic [6:0] OPCODE_LUI      = 7'b011_0111;
  localparam logic [6:0] OPCODE_MADD     = 7'b100_0011;
  localparam logic [6:0] OPCODE_MSUB     = 7'b100_0111;
  localparam logic [6:0] OPCODE_NMSUB    = 7'b100_1011;
  localparam logic [6:0] OPCODE_NMADD    = 7'b100_1111;
  localparam logic [6:0] OPCODE_OP_FP    = 7'b101_0011;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPCODE_JALR     = 7'b110_0111;
  localparam logic [6:0] OPCODE_JAL      = 7'b110_1111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b111_0011;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register: loads a fetched instruction, flushes to a NOP
// bubble, otherwise holds. Flush wins over load.
module if_id_pipeline_register #(
  parameter logic [31:0] NOP_INSTR = rv32_pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr    <= NOP_INSTR;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else if (flush) begin
      // PC fields are left as-is; only the instruction is neutralised
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr    <= instr;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, instruction-memory handshake, one-entry hold buffer for
// stalls and redirect handling, feeding the IF/ID register.
//
// state   | meaning
// IDLE    | one dead cycle after reset release, no request
// FETCH   | request at PC outstanding, waiting for busywait to drop
// HOLD    | fetched word parked in hold buffer while ID stalls
// DISCARD | redirected mid-access; finish the old access and drop its data
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = rv32_pipeline_pkg::RESET_VECTOR_DEFAULT,
  parameter logic [31:0] NOP_INSTR    = rv32_pipeline_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] ID_INSTRUCTION,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC_PLUS4,
  output logic        ID_VALID,
  output logic [31:0] FETCH_COUNT
);
  import rv32_pipeline_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_q, pending_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic         hold_full_q, hold_full_d;
  logic [31:0]  count_q, count_d;

  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;
  logic [31:0]  ifid_pc_plus4;
  logic [31:0]  target;

  assign target = align_word(BRANCH_TARGET);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= FS_IDLE;
      pc_q         <= RESET_VECTOR;
      pending_q    <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
      hold_full_q  <= 1'b0;
      count_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_full_q  <= hold_full_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_full_d  = hold_full_q;
    count_d      = count_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr   = IMEM_READDATA;
    ifid_pc      = pc_q;

    // A redirect always beats STALL: the stalling instruction is being flushed
    case (state_q)
      FS_IDLE: begin
        state_d = FS_FETCH;
        if (BRANCH_TAKEN) begin
          ifid_flush = 1'b1;
          pc_d       = target;
        end
      end
      FS_FETCH: begin
        if (BRANCH_TAKEN) begin
          ifid_flush = 1'b1;
          if (IMEM_BUSYWAIT) begin
            // address must stay put until the memory finishes
            pending_d = target;
            state_d   = FS_DISCARD;
          end else begin
            pc_d = target;
          end
        end else if (!IMEM_BUSYWAIT) begin
          if (STALL) begin
            hold_instr_d = IMEM_READDATA;
            hold_pc_d    = pc_q;
            hold_full_d  = 1'b1;
            state_d      = FS_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + 32'd4;
            count_d   = count_q + 32'd1;
          end
        end
      end
      FS_HOLD: begin
        if (BRANCH_TAKEN) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          state_d    = FS_FETCH;
        end else if (!STALL && hold_full_q) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_instr_q;
          ifid_pc    = hold_pc_q;
          pc_d       = hold_pc_q + 32'd4;
          count_d    = count_q + 32'd1;
          hold_full_d = 1'b0;
          state_d    = FS_FETCH;
        end
      end
      FS_DISCARD: begin
        if (BRANCH_TAKEN) begin
          ifid_flush = 1'b1;
          pending_d  = target;
        end
        if (!IMEM_BUSYWAIT) begin
          pc_d    = BRANCH_TAKEN ? target : pending_q;
          state_d = FS_FETCH;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    if (BRANCH_TAKEN) hold_full_d = 1'b0;
  end

  assign ifid_pc_plus4 = ifid_pc + 32'd4;
  assign IMEM_ADDRESS  = pc_q;
  assign IMEM_READ     = (state_q == FS_FETCH) || (state_q == FS_DISCARD);
  assign FETCH_COUNT   = count_q;

  if_id_pipeline_register #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk        (CLK),
    .rst        (RESET),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .instr      (ifid_instr),
    .pc         (ifid_pc),
    .pc_plus4   (ifid_pc_plus4),
    .id_instr   (ID_INSTRUCTION),
    .id_pc      (ID_PC),
    .id_pc_plus4(ID_PC_PLUS4),
    .id_valid   (ID_VALID)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed walk through the main scenarios,
// then random stall/busywait/redirect traffic against an instruction-stream model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        bt = 1'b0;
  logic [31:0] bt_target = 32'h0;
  logic        busy = 1'b0;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_readdata;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // stream model state
  logic [31:0] m_instr, m_pc, m_pc4, m_count, exp_next;
  logic        m_valid;
  int          free_run, max_free;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .CLK           (clk),
    .RESET         (rst),
    .STALL         (stall),
    .BRANCH_TAKEN  (bt),
    .BRANCH_TARGET (bt_target),
    .IMEM_ADDRESS  (imem_address),
    .IMEM_READ     (imem_read),
    .IMEM_READDATA (imem_readdata),
    .IMEM_BUSYWAIT (busy),
    .ID_INSTRUCTION(id_instruction),
    .ID_PC         (id_pc),
    .ID_PC_PLUS4   (id_pc_plus4),
    .ID_VALID      (id_valid),
    .FETCH_COUNT   (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  assign imem_readdata = mem_word(imem_address);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_read"},  imem_read, 0);
    check_eq({tag, "_addr"},  imem_address, 32'h0);
    check_eq({tag, "_instr"}, id_instruction, NOP);
    check_eq({tag, "_pc"},    id_pc, 32'h0);
    check_eq({tag, "_pc4"},   id_pc_plus4, 32'h0);
    check_eq({tag, "_valid"}, id_valid, 0);
    check_eq({tag, "_count"}, fetch_count, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev_addr;
    logic        prev_rd_busy;

    #2 rst = 1'b1;
    tick(); tick();
    check_reset_values("reset");

    // zero-wait startup
    rst = 1'b0;
    check_eq("idle_read", imem_read, 0);
    tick();
    check_eq("first_read", imem_read, 1);
    check_eq("first_addr", imem_address, 32'h0);
    tick();
    check_eq("first_instr", id_instruction, 32'h0050_0093);
    check_eq("first_pc", id_pc, 32'h0);
    check_eq("first_pc4", id_pc_plus4, 32'h4);
    check_eq("first_valid", id_valid, 1);
    tick();
    check_eq("seq_pc4", id_pc, 32'h4);
    tick();
    check_eq("seq_pc8", id_pc, 32'h8);
    check_eq("seq_count3", fetch_count, 32'd3);
    tick();
    check_eq("seq_addr10", imem_address, 32'h10);

    // busywait for three cycles on 0x10
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("busy_addr", imem_address, 32'h10);
      check_eq("busy_idpc", id_pc, 32'hC);
    end
    busy = 1'b0;
    tick();
    check_eq("busy_done_pc", id_pc, 32'h10);
    check_eq("busy_done_count", fetch_count, 32'd5);

    // stall for four cycles while 0x20 completes
    repeat (3) tick();
    check_eq("stall_addr", imem_address, 32'h20);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("hold_idpc", id_pc, 32'h1C);
      check_eq("hold_read", imem_read, 0);
    end
    stall = 1'b0;
    tick();
    check_eq("release_pc", id_pc, 32'h20);
    check_eq("release_addr", imem_address, 32'h24);
    check_eq("release_count", fetch_count, 32'd9);

    // redirect to 0x100 while 0x40 is busy
    for (int i = 0; i < 20 && imem_address != 32'h40; i++) tick();
    check_eq("reach_40", imem_address, 32'h40);
    busy = 1'b1; bt = 1'b1; bt_target = 32'h100;
    tick();
    bt = 1'b0;
    check_eq("disc_valid", id_valid, 0);
    check_eq("disc_instr", id_instruction, NOP);
    check_eq("disc_addr", imem_address, 32'h40);
    check_eq("disc_read", imem_read, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("disc_addr_hold", imem_address, 32'h40);
    end
    busy = 1'b0;
    tick();
    check_eq("disc_next_addr", imem_address, 32'h100);
    check_eq("disc_count", fetch_count, 32'd16);
    check_eq("disc_valid2", id_valid, 0);
    tick();
    check_eq("target_pc", id_pc, 32'h100);
    check_eq("target_valid", id_valid, 1);
    check_eq("target_count", fetch_count, 32'd17);

    // redirect with stall while a word sits in the hold buffer
    stall = 1'b1;
    tick();
    check_eq("hold2_read", imem_read, 0);
    bt = 1'b1; bt_target = 32'h203;
    tick();
    bt = 1'b0; stall = 1'b0;
    check_eq("hflush_valid", id_valid, 0);
    check_eq("hflush_addr", imem_address, 32'h200);
    check_eq("hflush_count", fetch_count, 32'd17);
    tick();
    check_eq("hflush_next_pc", id_pc, 32'h200);
    check_eq("hflush_next_count", fetch_count, 32'd18);

    // reset pulse in the middle of a busy access at 0x80
    bt = 1'b1; bt_target = 32'h80;
    tick();
    bt = 1'b0; busy = 1'b1;
    check_eq("pre_rst_addr", imem_address, 32'h80);
    tick();
    check_eq("pre_rst_read", imem_read, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    busy = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("post_rst_count", fetch_count, 32'h0);
    check_eq("post_rst_read", imem_read, 0);
    tick();
    check_eq("restart_read", imem_read, 1);
    check_eq("restart_addr", imem_address, 32'h0);
    tick();
    check_eq("restart_pc", id_pc, 32'h0);
    check_eq("restart_instr", id_instruction, 32'h0050_0093);
    check_eq("restart_count", fetch_count, 32'd1);

    // random traffic against the instruction-stream model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_instr = NOP; m_pc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_count = 32'h0; exp_next = 32'h0; free_run = 0; max_free = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stall = ($urandom_range(0, 3) == 0);
      busy  = ($urandom_range(0, 9) < 3);
      bt    = ($urandom_range(0, 11) == 0);
      bt_target = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFD : ($urandom & 32'h0000_3FFF);
      prev_addr    = imem_address;
      prev_rd_busy = imem_read && busy;
      tick();
      if (prev_rd_busy) begin
        check_eq("rnd_addr_stable", imem_address, prev_addr);
        check_eq("rnd_read_stable", imem_read, 1);
      end
      if (bt) begin
        m_instr  = NOP;
        m_valid  = 1'b0;
        exp_next = {bt_target[31:2], 2'b00};
        free_run = 0;
      end else if (fetch_count != m_count) begin
        if (stall) begin
          check_eq("rnd_deliver_in_stall", fetch_count, m_count);
        end else begin
          m_count  = m_count + 32'd1;
          m_instr  = mem_word(exp_next);
          m_pc     = exp_next;
          m_pc4    = exp_next + 32'd4;
          m_valid  = 1'b1;
          exp_next = exp_next + 32'd4;
          free_run = 0;
        end
      end else if (!stall && !busy) begin
        free_run++;
        if (free_run > max_free) max_free = free_run;
      end
      check_eq("rnd_count", fetch_count, m_count);
      check_eq("rnd_instr", id_instruction, m_instr);
      check_eq("rnd_valid", id_valid, m_valid);
      check_eq("rnd_pc", id_pc, m_pc);
      check_eq("rnd_pc4", id_pc_plus4, m_pc4);
    end
    bt = 1'b0; stall = 1'b0; busy = 1'b0;
    check_eq("rnd_max_idle_gap_ok", (max_free <= 2), 1);
    check_eq("rnd_progress", (m_count > 32'd100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
